// File: rtl/bcd_game_pkg.sv
// Shared types and constants for the BCD reaction-game sequencer.
package bcd_game_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_RUN   = 3'd2,
    ST_CHECK = 3'd3,
    ST_SHOW  = 3'd4
  } state_e;

  typedef logic [3:0] bcd_t;

  localparam bcd_t BCD_MAX = 4'd9;

  // Increment that pins at 9 so the score never leaves BCD range.
  function automatic bcd_t bcd_sat_inc(input bcd_t v);
    return (v >= BCD_MAX) ? BCD_MAX : bcd_t'(v + 4'd1);
  endfunction

endpackage

// File: rtl/game_tick_gen.sv
// Count-step prescaler: free-runs 0..TICK_DIV-1 unless held clear, flags the last count.
module game_tick_gen #(
  parameter int TICK_DIV = 4
) (
  input  logic i_clk,
  input  logic i_r_n,
  input  logic i_clr,
  output logic o_tick
);

  localparam int CW = $clog2(TICK_DIV);
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] r_cnt;

  // Prescaler counter with synchronous clear and wrap on the last count.
  always_ff @(posedge i_clk or negedge i_r_n) begin
    if (!i_r_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (r_cnt == LAST) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  assign o_tick = (r_cnt == LAST);

endmodule

// File: rtl/bcd_game_ctrl.sv
// Game sequencer for a BCD digit counter chain: strobes UP/CLR with decimal carry,
// freezes on STOP, grades against TARGET and keeps a saturating BCD score.
import bcd_game_pkg::*;

module bcd_game_ctrl #(
  parameter int NDIG     = 2,
  parameter int TICK_DIV = 4,
  parameter int SHOW_CYC = 8
) (
  input  logic              i_clk,
  input  logic              i_r_n,
  input  logic              i_start,
  input  logic              i_stop,
  input  logic [4*NDIG-1:0] i_target,
  input  logic [4*NDIG-1:0] i_num,
  output logic [NDIG-1:0]   o_up,
  output logic [NDIG-1:0]   o_clr,
  output logic [2:0]        o_state,
  output logic              o_hit,
  output logic              o_miss,
  output logic [3:0]        o_score
);

  localparam int SW = $clog2(SHOW_CYC + 1);
  localparam logic [SW-1:0] SHOW_LAST = SW'(SHOW_CYC - 1);

  state_e        r_state;
  logic          r_hit;
  logic          r_miss;
  bcd_t          r_score;
  logic [SW-1:0] r_show;

  logic            w_run;
  logic            w_clear;
  logic            w_tick;
  logic            w_wrap;
  logic [NDIG:0]   w_carry;

  assign w_run   = (r_state == ST_RUN);
  assign w_clear = (r_state == ST_CLEAR);

  game_tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick (
    .i_clk  (i_clk),
    .i_r_n  (i_r_n),
    .i_clr  (!w_run),
    .o_tick (w_tick)
  );

  assign w_carry[0] = w_run & w_tick;

  // Ripple decimal carry; corrupt digits (>9) behave like 9 and clear on carry.
  for (genvar gi = 0; gi < NDIG; gi++) begin : g_dig
    logic w_ge9;
    assign w_ge9           = (i_num[4*gi +: 4] >= BCD_MAX);
    assign w_carry[gi + 1] = w_carry[gi] & w_ge9;
    assign o_up[gi]        = w_carry[gi] & ~w_ge9;
    assign o_clr[gi]       = w_clear | (w_carry[gi] & w_ge9);
  end

  assign w_wrap = w_carry[NDIG];

  // Round sequencer, result flags, show timer and score.
  always_ff @(posedge i_clk or negedge i_r_n) begin
    if (!i_r_n) begin
      r_state <= ST_IDLE;
      r_hit   <= 1'b0;
      r_miss  <= 1'b0;
      r_score <= 4'd0;
      r_show  <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (i_start) begin
            r_state <= ST_CLEAR;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_CLEAR: begin
          r_state <= ST_RUN;
        end
        ST_RUN: begin
          // Overrun outranks a simultaneous STOP.
          if (w_wrap) begin
            r_miss  <= 1'b1;
            r_show  <= '0;
            r_state <= ST_SHOW;
          end else if (i_stop) begin
            r_state <= ST_CHECK;
          end else begin
            r_state <= ST_RUN;
          end
        end
        ST_CHECK: begin
          if (i_num == i_target) begin
            r_hit   <= 1'b1;
            r_score <= bcd_sat_inc(r_score);
          end else begin
            r_miss  <= 1'b1;
          end
          r_show  <= '0;
          r_state <= ST_SHOW;
        end
        ST_SHOW: begin
          if (r_show == SHOW_LAST) begin
            r_hit   <= 1'b0;
            r_miss  <= 1'b0;
            r_show  <= '0;
            r_state <= ST_IDLE;
          end else begin
            r_show  <= r_show + SW'(1);
          end
        end
        default: begin
          r_hit   <= 1'b0;
          r_miss  <= 1'b0;
          r_show  <= '0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_state = r_state;
  assign o_hit   = r_hit;
  assign o_miss  = r_miss;
  assign o_score = r_score;

endmodule

// File: tb/tb_bcd_game_ctrl.sv
// Self-checking bench: two modelled counter cells, rounds graded by a decimal-integer model.
import bcd_game_pkg::*;

module tb_bcd_game_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic [7:0] target = 8'h00;
  logic [7:0] num;
  logic [1:0] up;
  logic [1:0] clr;
  logic [2:0] state;
  logic       hit;
  logic       miss;
  logic [3:0] score;
  logic       load_en = 1'b0;
  logic [7:0] load_val = 8'h00;

  int n_checks = 0;
  int n_pass = 0;
  int score_m = 0;

  always #5 clk = ~clk;

  bcd_game_ctrl #(.NDIG(2), .TICK_DIV(4), .SHOW_CYC(8)) dut (
    .i_clk    (clk),
    .i_r_n    (rst_n),
    .i_start  (start),
    .i_stop   (stop),
    .i_target (target),
    .i_num    (num),
    .o_up     (up),
    .o_clr    (clr),
    .o_state  (state),
    .o_hit    (hit),
    .o_miss   (miss),
    .o_score  (score)
  );

  // Two counter cells: clear beats up; the bench can preload them.
  always @(posedge clk) begin
    if (load_en) begin
      num <= load_val;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (clr[i]) num[4*i +: 4] <= 4'd0;
        else if (up[i]) num[4*i +: 4] <= num[4*i +: 4] + 4'd1;
      end
    end
  end

  function automatic logic [7:0] to_bcd(input int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  // Expected strobes for a +1 step of decimal value v: changed digits go up, or clear when they roll to 0.
  function automatic void exp_strobe(input int v, output logic [1:0] eu, output logic [1:0] ec);
    int nv;
    int d;
    int n;
    nv = (v + 1) % 100;
    for (int i = 0; i < 2; i++) begin
      d = (i == 0) ? v % 10 : v / 10;
      n = (i == 0) ? nv % 10 : nv / 10;
      eu[i] = (n != d) && (n != 0);
      ec[i] = (n != d) && (n == 0);
    end
  endfunction

  task automatic play(input string tag, input int tgt, input int stop_at, input int load_at,
                      input int lval, input bit start_at_stop, input bit start_in_show);
    int v;
    int c;
    bit over;
    bit stopped;
    bit tick;
    bit exp_hit;
    logic [1:0] eu;
    logic [1:0] ec;
    target = to_bcd(tgt);
    @(negedge clk);
    n_checks++;
    if ({state, up, clr} !== {ST_IDLE, 2'b00, 2'b00})
      $display("FAIL %s_idle: got st=%0d up=%b clr=%b want st=0 up=00 clr=00", tag, state, up, clr);
    else n_pass++;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n_checks++;
    if ({state, up, clr} !== {ST_CLEAR, 2'b00, 2'b11})
      $display("FAIL %s_clear: got st=%0d up=%b clr=%b want st=1 up=00 clr=11", tag, state, up, clr);
    else n_pass++;
    v = 0; c = 0; over = 1'b0; stopped = 1'b0;
    while (!over && !stopped) begin
      @(negedge clk);
      stop     = (c == stop_at);
      start    = start_at_stop && (c == stop_at);
      load_en  = (c + 1 == load_at);
      load_val = to_bcd(lval);
      tick = (c % 4 == 3);
      if (tick) exp_strobe(v, eu, ec);
      else begin eu = 2'b00; ec = 2'b00; end
      n_checks++;
      if ({state, num, up, clr} !== {ST_RUN, to_bcd(v), eu, ec})
        $display("FAIL %s_run c=%0d: got st=%0d num=%h up=%b clr=%b want st=2 num=%h up=%b clr=%b",
                 tag, c, state, num, up, clr, to_bcd(v), eu, ec);
      else n_pass++;
      if (tick && v == 99) begin v = 0; over = 1'b1; end
      else if (tick) v++;
      if (c + 1 == load_at) v = lval;
      if (c == stop_at) stopped = 1'b1;
      c++;
      if (c > 2000) begin
        n_checks++;
        $display("FAIL %s_timeout: got no round end after %0d cycles want end", tag, c);
        over = 1'b1;
      end
    end
    @(negedge clk);
    stop = 1'b0; start = 1'b0; load_en = 1'b0;
    if (!over) begin
      n_checks++;
      if ({state, up, clr, num} !== {ST_CHECK, 2'b00, 2'b00, to_bcd(v)})
        $display("FAIL %s_check: got st=%0d up=%b clr=%b num=%h want st=3 up=00 clr=00 num=%h",
                 tag, state, up, clr, num, to_bcd(v));
      else n_pass++;
      exp_hit = (v == tgt);
      if (exp_hit && score_m < 9) score_m++;
      @(negedge clk);
    end else begin
      exp_hit = 1'b0;
    end
    for (int k = 0; k < 8; k++) begin
      n_checks++;
      if ({state, hit, miss, score, up, clr, num} !==
          {ST_SHOW, exp_hit, !exp_hit, 4'(score_m), 2'b00, 2'b00, to_bcd(v)})
        $display("FAIL %s_show k=%0d: got st=%0d hit=%b miss=%b score=%0d up=%b clr=%b num=%h want st=4 hit=%b miss=%b score=%0d num=%h",
                 tag, k, state, hit, miss, score, up, clr, num, exp_hit, !exp_hit, score_m, to_bcd(v));
      else n_pass++;
      start = start_in_show && (k == 2);
      stop  = start_in_show && (k == 4);
      @(negedge clk);
    end
    start = 1'b0; stop = 1'b0;
    n_checks++;
    if ({state, hit, miss, score} !== {ST_IDLE, 1'b0, 1'b0, 4'(score_m)})
      $display("FAIL %s_end: got st=%0d hit=%b miss=%b score=%0d want st=0 hit=0 miss=0 score=%0d",
               tag, state, hit, miss, score, score_m);
    else n_pass++;
  endtask

  task automatic test_reset;
    load_en = 1'b1; load_val = 8'h00;
    repeat (3) @(negedge clk);
    load_en = 1'b0;
    n_checks++;
    if ({state, hit, miss, score, up, clr} !== {ST_IDLE, 1'b0, 1'b0, 4'd0, 2'b00, 2'b00})
      $display("FAIL reset_init: got st=%0d hit=%b miss=%b score=%0d up=%b clr=%b want all 0",
               state, hit, miss, score, up, clr);
    else n_pass++;
    rst_n = 1'b1;
  endtask

  task automatic test_idle_stop;
    @(negedge clk);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    n_checks++;
    if ({state, up, clr} !== {ST_IDLE, 2'b00, 2'b00})
      $display("FAIL idle_stop: got st=%0d up=%b clr=%b want st=0", state, up, clr);
    else n_pass++;
  endtask

  task automatic test_saturate;
    for (int i = 0; i < 10; i++) play("sat", 42, 1, 1, 42, 1'b0, 1'b0);
    n_checks++;
    if (score !== 4'd9) $display("FAIL sat_score: got %0d want 9", score);
    else n_pass++;
  endtask

  task automatic test_random;
    int tgt;
    int lv;
    int sa;
    for (int i = 0; i < 8; i++) begin
      lv  = $urandom_range(0, 99);
      tgt = ($urandom_range(0, 1) == 1) ? lv : int'($urandom_range(0, 99));
      sa  = $urandom_range(1, 30);
      if ($urandom_range(0, 3) == 0) play("rand", tgt, sa + 40, -1, 0, 1'b0, 1'b0);
      else play("rand", tgt, sa, 1, lv, 1'b0, 1'b0);
    end
  endtask

  task automatic test_reset_mid;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    load_en = 1'b1; load_val = 8'h37;
    @(negedge clk);
    load_en = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({state, num, up} !== {ST_RUN, 8'h37, 2'b01})
      $display("FAIL rstmid_pre: got st=%0d num=%h up=%b want st=2 num=37 up=01", state, num, up);
    else n_pass++;
    #2 rst_n = 1'b0;
    #1;
    score_m = 0;
    n_checks++;
    if ({state, hit, miss, score, up, clr} !== {ST_IDLE, 1'b0, 1'b0, 4'd0, 2'b00, 2'b00})
      $display("FAIL rstmid: got st=%0d hit=%b miss=%b score=%0d up=%b clr=%b want all 0",
               state, hit, miss, score, up, clr);
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    play("after_rst", 0, 2, -1, 0, 1'b0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_idle_stop();
    play("count",   25, 43, -1, 0,  1'b0, 1'b0);
    play("carry",   25, 5,  1,  9,  1'b0, 1'b0);
    play("hit",     25, 2,  1,  25, 1'b0, 1'b0);
    play("miss",    25, 2,  1,  24, 1'b0, 1'b0);
    play("overrun", 25, -1, 1,  99, 1'b0, 1'b0);
    play("stopwrap", 0, 3,  1,  99, 1'b0, 1'b0);
    play("stoptick", 2, 7,  -1, 0,  1'b0, 1'b0);
    play("startstop", 14, 2, 1, 14, 1'b1, 1'b1);
    test_saturate();
    test_random();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
